// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO and runs MULT/DIV over a fixed cycle count.
// Optional feature: define MD_CANCEL_EN to add the Cancel input that aborts an operation in flight.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOpE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
`ifdef MD_CANCEL_EN
  input  logic        Cancel,
`endif
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOutE
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMfhi  = 4'd5,
    OpMflo  = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8
  } md_op_e;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       phi_q, phi_d, plo_q, plo_d;

  logic cancel;
`ifdef MD_CANCEL_EN
  assign cancel = Cancel;
`else
  assign cancel = 1'b0;
`endif

  logic is_mult, is_div, is_signed, mt_hi, mt_lo, rd_hi, rd_lo;

  always_comb begin
    is_mult   = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    rd_hi     = 1'b0;
    rd_lo     = 1'b0;
    case (MDOpE)
      OpMult:  begin is_mult = 1'b1; is_signed = 1'b1; end
      OpMultu: is_mult = 1'b1;
      OpDiv:   begin is_div = 1'b1; is_signed = 1'b1; end
      OpDivu:  is_div = 1'b1;
      OpMfhi:  rd_hi = 1'b1;
      OpMflo:  rd_lo = 1'b1;
      OpMthi:  mt_hi = 1'b1;
      OpMtlo:  mt_lo = 1'b1;
      default: ;
    endcase
  end

  // Shared sign handling: operands are magnitudes for the divider and sign/zero-extended
  // to 64 bits for the multiplier, whose low 64 product bits are exact either way.
  logic        a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, b_div, quo_mag, rem_mag;
  logic [31:0] res_hi, res_lo;

  assign a_neg   = is_signed & RD1E[31];
  assign b_neg   = is_signed & RD2E[31];
  assign a_ext   = {{32{a_neg}}, RD1E};
  assign b_ext   = {{32{b_neg}}, RD2E};
  assign prod    = a_ext * b_ext;
  assign a_mag   = a_neg ? (~RD1E + 32'd1) : RD1E;
  assign b_mag   = b_neg ? (~RD2E + 32'd1) : RD2E;
  assign b_div   = (RD2E == 32'd0) ? 32'd1 : b_mag;
  assign quo_mag = a_mag / b_div;
  assign rem_mag = a_mag % b_div;

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      if (RD2E == 32'd0) begin
        res_hi = RD1E;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_lo = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
        res_hi = a_neg ? (~rem_mag + 32'd1) : rem_mag;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    Start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!cancel) begin
          if (is_mult || is_div) begin
            Start   = 1'b1;
            phi_d   = res_hi;
            plo_d   = res_lo;
            cnt_d   = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            state_d = StBusy;
          end
          if (mt_hi) hi_d = RD1E;
          if (mt_lo) lo_d = RD1E;
        end
      end
      StBusy: begin
        // Cancel wins over the commit on the final cycle.
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
          phi_d   = '0;
          plo_d   = '0;
        end else if (cnt_q == CntW'(1)) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign Busy   = (state_q == StBusy);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MDOutE = rd_hi ? hi_q : (rd_lo ? lo_q : 32'd0);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops against an arithmetic model.
`timescale 1ns/1ps
module tb_md_unit;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;
`ifdef MD_CANCEL_EN
  localparam bit HasCancel = 1'b1;
`else
  localparam bit HasCancel = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cancel = 1'b0;
  logic        Start, Busy;
  logic [31:0] HI, LO, MDOutE;

  md_unit #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .MDOpE (op),
    .RD1E  (a),
    .RD2E  (b),
`ifdef MD_CANCEL_EN
    .Cancel(cancel),
`endif
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .MDOutE(MDOutE)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: cycles left in flight plus architectural and pending HI/LO.
  int          m_left;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    m_phi  = 32'd0;
    m_plo  = 32'd0;
  endtask

  function automatic void model_result(input logic [3:0] o, input logic [31:0] x,
                                       input logic [31:0] y, output logic [31:0] rh,
                                       output logic [31:0] rl);
    longint      sx, sy, q, r;
    logic [63:0] p;
    rh = 32'd0;
    rl = 32'd0;
    case (o)
      4'd1: begin
        p  = longint'($signed(x)) * longint'($signed(y));
        rh = p[63:32];
        rl = p[31:0];
      end
      4'd2: begin
        p  = {32'd0, x} * {32'd0, y};
        rh = p[63:32];
        rl = p[31:0];
      end
      4'd3: begin
        if (y == 32'd0) begin
          rl = 32'hFFFF_FFFF;
          rh = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000;
          rh = 32'd0;
        end else begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          q  = sx / sy;
          r  = sx % sy;
          rl = q[31:0];
          rh = r[31:0];
        end
      end
      4'd4: begin
        if (y == 32'd0) begin
          rl = 32'hFFFF_FFFF;
          rh = x;
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
      default: ;
    endcase
  endfunction

  // One cycle: apply inputs just after the falling edge, compare, clock, advance the model.
  task automatic step(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic c);
    logic        ec;
    logic [31:0] exp_out;
    op     = o;
    a      = x;
    b      = y;
    cancel = c;
    #1;
    ec      = HasCancel && c;
    exp_out = (o == 4'd5) ? m_hi : ((o == 4'd6) ? m_lo : 32'd0);
    check("start", {31'd0, Start}, {31'd0, (o >= 4'd1 && o <= 4'd4 && m_left == 0 && !ec)});
    check("busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
    check("mdout", MDOutE, exp_out);
    @(posedge clk);
    if (m_left > 0) begin
      if (ec) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_phi;
          m_lo = m_plo;
        end
      end
    end else if (!ec) begin
      if (o >= 4'd1 && o <= 4'd4) begin
        model_result(o, x, y, m_phi, m_plo);
        m_left = (o <= 4'd2) ? MultN : DivN;
      end else if (o == 4'd7) begin
        m_hi = x;
      end else if (o == 4'd8) begin
        m_lo = x;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 64) begin
      step(4'd0, $urandom, $urandom, 1'b0);
      n++;
    end
    if (n >= 64) check("drain_timeout", 32'(n), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    model_reset();
    #2;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    step(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    drain(n);
    check("mult_len", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    step(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    drain(n);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    drain(n);
    check("div_len", 32'(n), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    drain(n);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'd0);

    step(4'd4, 32'h0000_1234, 32'd0, 1'b0);
    drain(n);
    check("div0_len", 32'(n), 32'd10);
    check("div0_lo", LO, 32'hFFFF_FFFF);
    check("div0_hi", HI, 32'h0000_1234);

    step(4'd7, 32'hAAAA_5555, 32'd0, 1'b0);
    check("mthi", HI, 32'hAAAA_5555);
    step(4'd5, 32'd0, 32'd0, 1'b0);
    check("mfhi", MDOutE, 32'hAAAA_5555);

    step(4'd1, 32'd2, 32'd3, 1'b0);
    step(4'd8, 32'h1234_5678, 32'd0, 1'b0);
    check("mtlo_busy", LO, 32'hFFFF_FFFF);
    drain(n);
    check("mtlo_commit_lo", LO, 32'd6);
    check("mtlo_commit_hi", HI, 32'd0);

    // Async reset with the counter at 3.
    step(4'd7, 32'h5A5A_5A5A, 32'd0, 1'b0);
    step(4'd1, 32'd7, 32'd9, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    check("amid_busy", {31'd0, Busy}, 32'd0);
    check("amid_hi", HI, 32'd0);
    check("amid_lo", LO, 32'd0);
    model_reset();
    #1;
    reset = 1'b1;

`ifdef MD_CANCEL_EN
    step(4'd7, 32'h1111_1111, 32'd0, 1'b0);
    step(4'd8, 32'h2222_2222, 32'd0, 1'b0);
    step(4'd3, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 3; i++) step(4'd0, 32'd0, 32'd0, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b1);
    check("cancel4_busy", {31'd0, Busy}, 32'd0);
    check("cancel4_hi", HI, 32'h1111_1111);
    check("cancel4_lo", LO, 32'h2222_2222);
    step(4'd3, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 9; i++) step(4'd0, 32'd0, 32'd0, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b1);
    check("cancel_last_busy", {31'd0, Busy}, 32'd0);
    check("cancel_last_lo", LO, 32'h2222_2222);
    step(4'd1, 32'd3, 32'd3, 1'b1);
    check("cancel_idle", {31'd0, Busy}, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), pick(), pick(), ($urandom_range(0, 19) == 0));
    end
    drain(n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline; owns the HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles, and MFHI/MFLO/MTHI/MTLO in a single cycle.
- Drives Start/Busy, which the hazard unit consumes for MD stalls: any MD instruction in D stalls while Start|Busy.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high after a MULT/MULTU start (must be >=1).
- DIV_CYCLES, 10, cycles Busy stays high after a DIV/DIVU start (must be >=1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- MDOpE  input  4  0=NONE, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MFHI, 6=MFLO, 7=MTHI, 8=MTLO; others treated as NONE
- RD1E  input  32  rs operand (post-forwarding)
- RD2E  input  32  rt operand (post-forwarding)
- Start  output  1  combinational; high when MDOpE is 1..4 and the unit is IDLE
- Busy  output  1  registered; high while an operation is in flight
- HI  output  32  HI register
- LO  output  32  LO register
- MDOutE  output  32  combinational: HI if MFHI, LO if MFLO, else 0

Behaviour:
- Reset (reset==0, async): state=IDLE, Busy=0, HI=0, LO=0, counter=0, pending results=0. Reset mid-operation discards the operation.
- FSM states:
  - IDLE: on an edge with Start=1, latch RD1E/RD2E, compute the 64-bit result into pendHI/pendLO, load counter with MULT_CYCLES or DIV_CYCLES, go to BUSY, Busy<=1.
  - BUSY: counter decrements each edge. On the edge where counter==1, HI<=pendHI, LO<=pendLO, Busy<=0, go to IDLE.
  - Busy is therefore high for exactly N cycles after the start cycle.
  - HI/LO keep their old values until commit; MFHI during BUSY cannot occur because the hazard unit stalls it.
- Arithmetic:
  - MULT: signed 32x32->64; HI=[63:32], LO=[31:0]. MULTU: unsigned.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero (either signedness): LO=0xFFFFFFFF, HI=dividend. Still takes DIV_CYCLES.
- MTHI/MTLO: write RD1E to HI/LO on the edge, IDLE only. Ignored in BUSY. Takes no cycles and does not assert Busy.
- A mult/div op presented while BUSY is ignored (Start=0). The hazard unit prevents this; the unit must still never restart mid-operation.
- Back-to-back: a new op may start on the same edge that Busy falls? No. The commit edge leaves the unit IDLE, so the earliest restart is the following cycle, where Start=1 and Busy=0.
- Simultaneous events: the commit edge and an MTHI/MTLO cannot coincide, because MT* is ignored in BUSY.

Optional Feature:
- Macro MD_CANCEL_EN.
- Defined: adds input port Cancel (1 bit). Cancel=1 in BUSY returns to IDLE at the next edge with Busy<=0, HI/LO unchanged, pending result dropped. Cancel=1 in IDLE suppresses Start and any MT* write that cycle. Cancel has priority over commit when counter==1.
- Undefined: no Cancel port; started operations always complete.

Test Plan:
- Reset with reset=0 mid-MULT (counter=3) -> Busy=0, HI=0, LO=0 immediately, before the next clock edge.
- MULT RD1E=0xFFFFFFFE (-2), RD2E=3 -> Start=1 one cycle; Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV RD1E=0xFFFFFFF9 (-7), RD2E=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 -> after 10 cycles LO=0xFFFFFFFF, HI=0x00001234.
- MTHI 0xAAAA5555 in IDLE -> HI=0xAAAA5555 next edge; MFHI then gives MDOutE=0xAAAA5555. MTLO during BUSY -> LO unchanged until commit.
- With MD_CANCEL_EN: start DIV, assert Cancel on the 4th Busy cycle -> Busy=0 next edge, HI/LO hold pre-DIV values. Cancel on the final (counter==1) cycle -> no commit.
